// File: rtl/fetch_stall_ctrl_if.sv
// Bus bundle between the fetch controller and its environment: stall unit
// hazard inputs, EX redirect, instruction memory port and IF/ID outputs.
interface fetch_stall_ctrl_if;
  logic        stall_req;
  logic [31:0] stall_pc;
  logic [31:0] stall_inst;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic [31:0] imem_rdata;
  logic [31:0] imem_addr;
  logic [31:0] fd_inst;
  logic [31:0] fd_pc;
  logic        fd_valid;
  logic        de_bubble;
  logic [15:0] stall_count;
  logic        stall_err;

  // Controller side
  modport slave (
    input  stall_req, stall_pc, stall_inst, redirect_en, redirect_pc, imem_rdata,
    output imem_addr, fd_inst, fd_pc, fd_valid, de_bubble, stall_count, stall_err
  );

  // Pipeline / memory side
  modport master (
    output stall_req, stall_pc, stall_inst, redirect_en, redirect_pc, imem_rdata,
    input  imem_addr, fd_inst, fd_pc, fd_valid, de_bubble, stall_count, stall_err
  );
endinterface

// File: rtl/fetch_stall_ctrl.sv
// Fetch-side PC and IF/ID register controller. Freezes the PC and re-presents
// the held instruction on load-use stalls, flushes IF/ID on EX redirects,
// and keeps saturating stall statistics for debug.
module fetch_stall_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INST  = 32'h0000_0013,
  parameter int unsigned MAX_STALL = 4
) (
  input  logic              clk,
  input  logic              rst,
  fetch_stall_ctrl_if.slave bus
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [31:0] pc_q, pc_d;
  logic [31:0] fd_inst_q, fd_inst_d;
  logic [31:0] fd_pc_q, fd_pc_d;
  logic        fd_valid_q, fd_valid_d;
  logic [0:0]  state_q, state_d;
  logic [7:0]  run_len_q, run_len_d;
  logic [15:0] stall_count_q, stall_count_d;
  logic        stall_err_q, stall_err_d;

  logic        eff_stall;
  logic [8:0]  run_len_inc;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // A held NOP (fd_valid low) or the flush cycle cannot carry a hazard,
  // so stall requests are only honoured in RUN with a real instruction.
  always_comb begin
    eff_stall     = bus.stall_req & fd_valid_q & (state_q == ST_RUN);
    bus.de_bubble = bus.redirect_en | eff_stall;
  end

  // Next-state selection: redirect beats stall, stall beats normal fetch.
  always_comb begin
    pc_d          = pc_q;
    fd_inst_d     = fd_inst_q;
    fd_pc_d       = fd_pc_q;
    fd_valid_d    = fd_valid_q;
    state_d       = state_q;
    run_len_d     = 8'd0;
    stall_count_d = stall_count_q;
    stall_err_d   = stall_err_q;
    run_len_inc   = {1'b0, run_len_q} + 9'd1;

    if (bus.redirect_en) begin
      pc_d       = {bus.redirect_pc[31:2], 2'b00};
      fd_inst_d  = NOP_INST;
      fd_valid_d = 1'b0;
      state_d    = ST_FLUSH;
    end else if (eff_stall) begin
      fd_inst_d     = bus.stall_inst;
      fd_pc_d       = bus.stall_pc;
      run_len_d     = sat_inc8(run_len_q);
      stall_count_d = sat_inc16(stall_count_q);
      if (run_len_inc > 9'(MAX_STALL)) begin
        stall_err_d = 1'b1;
      end
    end else begin
      fd_inst_d  = bus.imem_rdata;
      fd_pc_d    = pc_q;
      fd_valid_d = 1'b1;
      pc_d       = pc_q + 32'd4;
      state_d    = ST_RUN;
    end
  end

  // State registers; reset overrides any in-flight stall or flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      fd_inst_q     <= NOP_INST;
      fd_pc_q       <= 32'd0;
      fd_valid_q    <= 1'b0;
      state_q       <= ST_RUN;
      run_len_q     <= 8'd0;
      stall_count_q <= 16'd0;
      stall_err_q   <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      fd_inst_q     <= fd_inst_d;
      fd_pc_q       <= fd_pc_d;
      fd_valid_q    <= fd_valid_d;
      state_q       <= state_d;
      run_len_q     <= run_len_d;
      stall_count_q <= stall_count_d;
      stall_err_q   <= stall_err_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.fd_inst     = fd_inst_q;
  assign bus.fd_pc       = fd_pc_q;
  assign bus.fd_valid    = fd_valid_q;
  assign bus.stall_count = stall_count_q;
  assign bus.stall_err   = stall_err_q;

endmodule
